// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and serial line levels.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx_framer_if.sv
// Word-in / serial-out bundle between the synchronizer side and the UART framer.
interface uart_tx_framer_if #(
   parameter int DATA_WIDTH = 8
);

   logic                  data_valid;
   logic [DATA_WIDTH-1:0] data;
   logic                  parity_enable;
   logic                  parity_type;
   logic                  serial_out;
   logic                  busy;
   logic                  overrun;

   modport master (
      output data_valid,
      output data,
      output parity_enable,
      output parity_type,
      input  serial_out,
      input  busy,
      input  overrun
   );

   modport slave (
      input  data_valid,
      input  data,
      input  parity_enable,
      input  parity_type,
      output serial_out,
      output busy,
      output overrun
   );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last count.
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic restart,
   output logic bit_done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count;

   assign bit_done = enable && (count == LAST_COUNT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (restart) begin
         count <= '0;
      end else if (enable) begin
         if (bit_done) begin
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: one-word pending buffer behind the frame in flight,
// start + data (LSB first) + optional parity + stop, with overrun reporting.
module uart_tx_framer
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input logic              clk,
   input logic              reset,
   uart_tx_framer_if.slave  bus
);

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   state_t                state;
   state_t                state_next;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] shift_next;
   logic [IDX_W-1:0]      bit_idx;
   logic [IDX_W-1:0]      bit_idx_next;
   logic                  par_en;
   logic                  par_en_next;
   logic                  par_bit;
   logic                  par_bit_next;

   logic                  pend_valid;
   logic                  pend_valid_next;
   logic [DATA_WIDTH-1:0] pend_data;
   logic [DATA_WIDTH-1:0] pend_data_next;
   logic                  pend_par_en;
   logic                  pend_par_en_next;
   logic                  pend_par_bit;
   logic                  pend_par_bit_next;

   logic                  load_pend;
   logic                  load_in;
   logic                  drop;
   logic                  line_next;
   logic                  serial_q;
   logic                  overrun_q;
   logic                  bit_done;
   logic                  in_par_bit;

   // Parity is resolved at acceptance so later config changes cannot reach the frame.
   assign in_par_bit = (^bus.data) ^ bus.parity_type;

   uart_baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .reset    (reset),
      .enable   (state != IDLE),
      .restart  (state == IDLE),
      .bit_done (bit_done)
   );

   always_comb begin
      state_next        = state;
      shift_next        = shift_reg;
      bit_idx_next      = bit_idx;
      par_en_next       = par_en;
      par_bit_next      = par_bit;
      pend_valid_next   = pend_valid;
      pend_data_next    = pend_data;
      pend_par_en_next  = pend_par_en;
      pend_par_bit_next = pend_par_bit;
      load_pend         = 1'b0;
      load_in           = 1'b0;
      drop              = 1'b0;
      line_next         = IDLE_LEVEL;

      case (state)
         IDLE: begin
            if (pend_valid) begin
               load_pend = 1'b1;
            end else if (bus.data_valid) begin
               load_in = 1'b1;
            end
         end
         START: begin
            if (bit_done) begin
               state_next   = DATA;
               bit_idx_next = '0;
            end
         end
         DATA: begin
            if (bit_done) begin
               shift_next = shift_reg >> 1;
               if (bit_idx == LAST_IDX) begin
                  state_next = par_en ? PARITY : STOP;
               end else begin
                  bit_idx_next = bit_idx + 1'b1;
               end
            end
         end
         PARITY: begin
            if (bit_done) begin
               state_next = STOP;
            end
         end
         STOP: begin
            if (bit_done) begin
               if (pend_valid) begin
                  load_pend = 1'b1;
               end else if (bus.data_valid) begin
                  load_in = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (load_pend) begin
         state_next      = START;
         shift_next      = pend_data;
         par_en_next     = pend_par_en;
         par_bit_next    = pend_par_bit;
         pend_valid_next = 1'b0;
      end

      if (load_in) begin
         state_next   = START;
         shift_next   = bus.data;
         par_en_next  = bus.parity_enable;
         par_bit_next = in_par_bit;
      end

      // A word arriving while the slot is being drained takes that slot.
      if (bus.data_valid && !load_in) begin
         if (!pend_valid || load_pend) begin
            pend_valid_next   = 1'b1;
            pend_data_next    = bus.data;
            pend_par_en_next  = bus.parity_enable;
            pend_par_bit_next = in_par_bit;
         end else begin
            drop = 1'b1;
         end
      end

      case (state_next)
         IDLE:    line_next = IDLE_LEVEL;
         START:   line_next = START_LEVEL;
         DATA:    line_next = shift_next[0];
         PARITY:  line_next = par_bit_next;
         STOP:    line_next = STOP_LEVEL;
         default: line_next = IDLE_LEVEL;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         bit_idx    <= '0;
         pend_valid <= 1'b0;
         serial_q   <= IDLE_LEVEL;
         overrun_q  <= 1'b0;
      end else begin
         state      <= state_next;
         bit_idx    <= bit_idx_next;
         pend_valid <= pend_valid_next;
         serial_q   <= line_next;
         overrun_q  <= drop;
      end
   end

   always_ff @(posedge clk) begin
      shift_reg    <= shift_next;
      par_en       <= par_en_next;
      par_bit      <= par_bit_next;
      pend_data    <= pend_data_next;
      pend_par_en  <= pend_par_en_next;
      pend_par_bit <= pend_par_bit_next;
   end

   assign bus.serial_out = serial_q;
   assign bus.busy       = (state != IDLE) | pend_valid;
   assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed testbench for uart_tx_framer (DATA_WIDTH=8, CLKS_PER_BIT=4).
module tb_uart_tx_framer;

   localparam int CPB = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   uart_tx_framer_if #(.DATA_WIDTH(8)) bus ();

   uart_tx_framer #(
      .DATA_WIDTH   (8),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic       s_valid [0:127];
   logic [7:0] s_data  [0:127];
   logic       s_pen   [0:127];
   logic       s_ptype [0:127];
   logic       c_ser   [0:127];
   logic       c_busy  [0:127];
   logic       c_ovr   [0:127];

   task automatic clear_sched(input logic pen, input logic ptype);
      for (int i = 0; i < 128; i++) begin
         s_valid[i] = 1'b0;
         s_data[i]  = 8'h00;
         s_pen[i]   = pen;
         s_ptype[i] = ptype;
      end
   endtask

   // Cycle c: drive schedule entry c just after the edge, capture outputs on the falling edge.
   task automatic run(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         #1;
         bus.data_valid    = s_valid[c];
         bus.data          = s_data[c];
         bus.parity_enable = s_pen[c];
         bus.parity_type   = s_ptype[c];
         @(negedge clk);
         c_ser[c]  = bus.serial_out;
         c_busy[c] = bus.busy;
         c_ovr[c]  = bus.overrun;
      end
   endtask

   // Expected line level i cycles into a frame.
   function automatic logic exp_bit(input logic [7:0] d, input logic pen, input logic ptype, input int i);
      int k;
      k = i / CPB;
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
      if (pen && k == 9) return (^d) ^ ptype;
      return 1'b1;
   endfunction

   task automatic test_reset();
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.serial_out !== 1'b1) $display("FAIL reset_serial: got %b want 1", bus.serial_out); else n_pass++;
      n_checks++;
      if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
      n_checks++;
      if (bus.overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", bus.overrun); else n_pass++;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.serial_out !== 1'b1 || bus.busy !== 1'b0)
         $display("FAIL post_reset_idle: got ser=%b busy=%b want ser=1 busy=0", bus.serial_out, bus.busy);
      else n_pass++;
   endtask

   task automatic test_basic();
      logic exp_a5 [0:9];
      exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      clear_sched(1'b0, 1'b0);
      s_valid[0] = 1'b1;
      s_data[0]  = 8'hA5;
      run(42);
      n_checks++;
      if (c_ser[0] !== 1'b1) $display("FAIL a5_latency: got %b want 1 before start", c_ser[0]); else n_pass++;
      for (int i = 0; i < 40; i++) begin
         n_checks++;
         if (c_ser[1+i] !== exp_a5[i/CPB])
            $display("FAIL a5_bit cycle %0d: got %b want %b", 1 + i, c_ser[1+i], exp_a5[i/CPB]);
         else n_pass++;
         n_checks++;
         if (c_busy[1+i] !== 1'b1) $display("FAIL a5_busy cycle %0d: got %b want 1", 1 + i, c_busy[1+i]); else n_pass++;
      end
      n_checks++;
      if (c_ser[41] !== 1'b1 || c_busy[41] !== 1'b0)
         $display("FAIL a5_end: got ser=%b busy=%b want ser=1 busy=0", c_ser[41], c_busy[41]);
      else n_pass++;
   endtask

   task automatic test_parity();
      logic [7:0] t_data [0:2];
      logic       t_type [0:2];
      logic       t_par  [0:2];
      t_data = '{8'h07, 8'h07, 8'h00};
      t_type = '{1'b0, 1'b1, 1'b0};
      t_par  = '{1'b1, 1'b0, 1'b0};
      for (int t = 0; t < 3; t++) begin
         clear_sched(1'b1, t_type[t]);
         s_valid[0] = 1'b1;
         s_data[0]  = t_data[t];
         // Config flips mid-frame on the odd case; the frame must not notice.
         if (t == 1) begin
            for (int c = 5; c < 128; c++) begin
               s_pen[c]   = 1'b0;
               s_ptype[c] = 1'b0;
            end
         end
         run(46);
         for (int i = 0; i < 44; i++) begin
            n_checks++;
            if (c_ser[1+i] !== exp_bit(t_data[t], 1'b1, t_type[t], i))
               $display("FAIL parity_frame%0d cycle %0d: got %b want %b", t, 1 + i, c_ser[1+i],
                        exp_bit(t_data[t], 1'b1, t_type[t], i));
            else n_pass++;
         end
         n_checks++;
         if (c_ser[38] !== t_par[t]) $display("FAIL parity_bit%0d: got %b want %b", t, c_ser[38], t_par[t]); else n_pass++;
         n_checks++;
         if (c_busy[44] !== 1'b1 || c_busy[45] !== 1'b0)
            $display("FAIL parity_len%0d: got busy44=%b busy45=%b want 1,0", t, c_busy[44], c_busy[45]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic all_busy;
      logic any_ovr;
      clear_sched(1'b0, 1'b0);
      s_valid[0]  = 1'b1;
      s_data[0]   = 8'h11;
      s_valid[10] = 1'b1;
      s_data[10]  = 8'h22;
      run(82);
      all_busy = 1'b1;
      any_ovr  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         n_checks++;
         if (c_ser[1+i] !== exp_bit(8'h11, 1'b0, 1'b0, i))
            $display("FAIL b2b_first cycle %0d: got %b want %b", 1 + i, c_ser[1+i], exp_bit(8'h11, 1'b0, 1'b0, i));
         else n_pass++;
         n_checks++;
         if (c_ser[41+i] !== exp_bit(8'h22, 1'b0, 1'b0, i))
            $display("FAIL b2b_second cycle %0d: got %b want %b", 41 + i, c_ser[41+i], exp_bit(8'h22, 1'b0, 1'b0, i));
         else n_pass++;
      end
      for (int c = 1; c <= 80; c++) begin
         all_busy = all_busy & c_busy[c];
         any_ovr  = any_ovr | c_ovr[c];
      end
      n_checks++;
      if (all_busy !== 1'b1) $display("FAIL b2b_busy_gap: got %b want 1 across both frames", all_busy); else n_pass++;
      n_checks++;
      if (any_ovr !== 1'b0) $display("FAIL b2b_overrun: got %b want 0", any_ovr); else n_pass++;
      n_checks++;
      if (c_busy[81] !== 1'b0 || c_ser[81] !== 1'b1)
         $display("FAIL b2b_end: got busy=%b ser=%b want 0,1", c_busy[81], c_ser[81]);
      else n_pass++;
   endtask

   task automatic test_overrun();
      int n_ovr;
      clear_sched(1'b0, 1'b0);
      s_valid[0]  = 1'b1;
      s_data[0]   = 8'h11;
      s_valid[5]  = 1'b1;
      s_data[5]   = 8'h22;
      s_valid[10] = 1'b1;
      s_data[10]  = 8'h33;
      run(82);
      n_ovr = 0;
      for (int c = 0; c < 82; c++) n_ovr += int'(c_ovr[c]);
      n_checks++;
      if (n_ovr != 1) $display("FAIL ovr_count: got %0d want 1", n_ovr); else n_pass++;
      n_checks++;
      if (c_ovr[11] !== 1'b1) $display("FAIL ovr_timing: got %b at cycle 11 want 1", c_ovr[11]); else n_pass++;
      for (int i = 0; i < 40; i++) begin
         n_checks++;
         if (c_ser[1+i] !== exp_bit(8'h11, 1'b0, 1'b0, i))
            $display("FAIL ovr_first cycle %0d: got %b want %b", 1 + i, c_ser[1+i], exp_bit(8'h11, 1'b0, 1'b0, i));
         else n_pass++;
         n_checks++;
         if (c_ser[41+i] !== exp_bit(8'h22, 1'b0, 1'b0, i))
            $display("FAIL ovr_second cycle %0d: got %b want %b", 41 + i, c_ser[41+i], exp_bit(8'h22, 1'b0, 1'b0, i));
         else n_pass++;
      end
      n_checks++;
      if (c_busy[81] !== 1'b0 || c_ser[81] !== 1'b1)
         $display("FAIL ovr_end: got busy=%b ser=%b want 0,1", c_busy[81], c_ser[81]);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      clear_sched(1'b0, 1'b0);
      s_valid[0] = 1'b1;
      s_data[0]  = 8'h96;
      s_valid[3] = 1'b1;
      s_data[3]  = 8'h77;
      run(19);
      n_checks++;
      if (c_ser[18] !== 1'b0 || c_busy[18] !== 1'b1)
         $display("FAIL rstmid_bit3: got ser=%b busy=%b want 0,1", c_ser[18], c_busy[18]);
      else n_pass++;
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (bus.serial_out !== 1'b1 || bus.busy !== 1'b0 || bus.overrun !== 1'b0)
         $display("FAIL rstmid_immediate: got ser=%b busy=%b ovr=%b want 1,0,0", bus.serial_out, bus.busy, bus.overrun);
      else n_pass++;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      clear_sched(1'b0, 1'b0);
      s_valid[0] = 1'b1;
      s_data[0]  = 8'h5A;
      run(42);
      n_checks++;
      if (c_ser[0] !== 1'b1 || c_busy[0] !== 1'b0)
         $display("FAIL rstmid_idle: got ser=%b busy=%b want 1,0", c_ser[0], c_busy[0]);
      else n_pass++;
      for (int i = 0; i < 40; i++) begin
         n_checks++;
         if (c_ser[1+i] !== exp_bit(8'h5A, 1'b0, 1'b0, i))
            $display("FAIL rstmid_5a cycle %0d: got %b want %b", 1 + i, c_ser[1+i], exp_bit(8'h5A, 1'b0, 1'b0, i));
         else n_pass++;
      end
      n_checks++;
      if (c_busy[41] !== 1'b0 || c_ser[41] !== 1'b1)
         $display("FAIL rstmid_flushed: got busy=%b ser=%b want 0,1", c_busy[41], c_ser[41]);
      else n_pass++;
   endtask

   task automatic test_stop_reload();
      logic all_busy;
      logic any_ovr;
      clear_sched(1'b0, 1'b0);
      s_valid[0]  = 1'b1;
      s_data[0]   = 8'h11;
      s_valid[5]  = 1'b1;
      s_data[5]   = 8'h22;
      s_valid[40] = 1'b1;
      s_data[40]  = 8'h3C;
      run(122);
      all_busy = 1'b1;
      any_ovr  = 1'b0;
      for (int c = 1; c <= 120; c++) begin
         all_busy = all_busy & c_busy[c];
         any_ovr  = any_ovr | c_ovr[c];
      end
      n_checks++;
      if (any_ovr !== 1'b0) $display("FAIL reload_overrun: got %b want 0", any_ovr); else n_pass++;
      n_checks++;
      if (all_busy !== 1'b1) $display("FAIL reload_busy: got %b want 1 across three frames", all_busy); else n_pass++;
      for (int i = 0; i < 40; i++) begin
         n_checks++;
         if (c_ser[41+i] !== exp_bit(8'h22, 1'b0, 1'b0, i))
            $display("FAIL reload_second cycle %0d: got %b want %b", 41 + i, c_ser[41+i], exp_bit(8'h22, 1'b0, 1'b0, i));
         else n_pass++;
         n_checks++;
         if (c_ser[81+i] !== exp_bit(8'h3C, 1'b0, 1'b0, i))
            $display("FAIL reload_third cycle %0d: got %b want %b", 81 + i, c_ser[81+i], exp_bit(8'h3C, 1'b0, 1'b0, i));
         else n_pass++;
      end
      n_checks++;
      if (c_busy[121] !== 1'b0 || c_ser[121] !== 1'b1)
         $display("FAIL reload_end: got busy=%b ser=%b want 0,1", c_busy[121], c_ser[121]);
      else n_pass++;
   endtask

   initial begin
      bus.data_valid    = 1'b0;
      bus.data          = 8'h00;
      bus.parity_enable = 1'b0;
      bus.parity_type   = 1'b0;
      test_reset();
      test_basic();
      test_parity();
      test_back_to_back();
      test_overrun();
      test_reset_mid();
      test_stop_reload();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
